// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for a bank of 2-bit saturating-counter predictors.
// After reset it sweeps every table index with init strobes. It then keeps
// in-flight predictions in an in-order queue, pairs each one with its EX-stage
// resolution, and issues one counter-update strobe per resolved branch.
// A direction mismatch empties the queue and opens a flush window.
module branch_resolve_ctrl #(
    parameter int IDX_W     = 4,
    parameter int QLOG2     = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    input  logic [IDX_W-1:0] pred_idx_i,
    output logic             pred_ready_o,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    output logic             upd_en_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output logic             upd_result_o,
    output logic             init_o,
    output logic             mispredict_o,
    output logic             flush_o,
    output logic [QLOG2:0]   count_o
);

    localparam int DEPTH = 1 << QLOG2;
    localparam int ENT_W = IDX_W + 1;
    // The flush counter holds FLUSH_CYC-1 down to 0; keep it at least 1 bit wide.
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = '1;
    localparam logic [QLOG2:0]   DEPTH_CNT  = (QLOG2+1)'(DEPTH);
    localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   init_cnt_reg;
    logic [QLOG2-1:0]   wr_ptr_reg;
    logic [QLOG2-1:0]   rd_ptr_reg;
    logic [QLOG2:0]     count_reg;
    logic [FC_W-1:0]    flush_cnt_reg;

    // Each entry is {predicted_taken, table_index}.
    logic [ENT_W-1:0]   queue_mem [DEPTH];

    logic               in_run;
    logic               push;
    logic               pop;
    logic               mismatch;
    logic [ENT_W-1:0]   head_entry;
    logic               head_taken;
    logic [IDX_W-1:0]   head_idx;

    // Handshake and queue-control decode from the current state.
    always_comb begin
        in_run       = (state_reg == ST_RUN);
        // A full queue refuses a push even if a pop happens in the same cycle.
        pred_ready_o = in_run && (count_reg < DEPTH_CNT);
        push         = pred_valid_i && pred_ready_o;
        pop          = in_run && res_valid_i && (count_reg != '0);
        head_entry   = queue_mem[rd_ptr_reg];
        head_taken   = head_entry[IDX_W];
        head_idx     = head_entry[IDX_W-1:0];
        mismatch     = pop && (head_taken != res_taken_i);
        count_o      = count_reg;
    end

    // Queue storage: no reset needed, validity is tracked by count/pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            queue_mem[wr_ptr_reg] <= {pred_taken_i, pred_idx_i};
        end
    end

    // Main sequencer: init sweep, in-order resolution, flush window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            flush_cnt_reg <= '0;
            upd_en_o      <= 1'b0;
            upd_idx_o     <= '0;
            upd_result_o  <= 1'b0;
            init_o        <= 1'b0;
            mispredict_o  <= 1'b0;
            flush_o       <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    upd_en_o     <= 1'b1;
                    init_o       <= 1'b1;
                    upd_idx_o    <= init_cnt_reg;
                    mispredict_o <= 1'b0;
                    flush_o      <= 1'b0;
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (init_cnt_reg == LAST_IDX) begin
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    upd_en_o     <= pop;
                    init_o       <= 1'b0;
                    mispredict_o <= mismatch;
                    flush_o      <= mismatch;
                    if (pop) begin
                        upd_idx_o    <= head_idx;
                        upd_result_o <= res_taken_i;
                    end
                    if (mismatch) begin
                        // Everything younger than the mispredicted branch is
                        // wrong-path, including a push arriving this cycle.
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        count_reg     <= '0;
                        flush_cnt_reg <= FLUSH_LOAD;
                        state_reg     <= ST_FLUSH;
                    end else begin
                        if (push) begin
                            wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        end
                        case ({push, pop})
                            2'b10:   count_reg <= count_reg + 1'b1;
                            2'b01:   count_reg <= count_reg - 1'b1;
                            default: count_reg <= count_reg;
                        endcase
                    end
                end

                ST_FLUSH: begin
                    upd_en_o     <= 1'b0;
                    init_o       <= 1'b0;
                    mispredict_o <= 1'b0;
                    if (flush_cnt_reg == '0) begin
                        flush_o   <= 1'b0;
                        state_reg <= ST_RUN;
                    end else begin
                        flush_o       <= 1'b1;
                        flush_cnt_reg <= flush_cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl. A behavioural model (a queue of
// outstanding predictions plus sweep/flush countdowns) predicts every output
// after each clock edge; directed scenarios are followed by a random phase.
module tb_branch_resolve_ctrl;

    localparam int IDX_W     = 4;
    localparam int QLOG2     = 2;
    localparam int FLUSH_CYC = 2;
    localparam int DEPTH     = 1 << QLOG2;
    localparam int ENTRIES   = 1 << IDX_W;

    logic             clk_i;
    logic             rst_i;
    logic             pred_valid_i;
    logic             pred_taken_i;
    logic [IDX_W-1:0] pred_idx_i;
    logic             pred_ready_o;
    logic             res_valid_i;
    logic             res_taken_i;
    logic             upd_en_o;
    logic [IDX_W-1:0] upd_idx_o;
    logic             upd_result_o;
    logic             init_o;
    logic             mispredict_o;
    logic             flush_o;
    logic [QLOG2:0]   count_o;

    branch_resolve_ctrl #(
        .IDX_W     (IDX_W),
        .QLOG2     (QLOG2),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pred_valid_i (pred_valid_i),
        .pred_taken_i (pred_taken_i),
        .pred_idx_i   (pred_idx_i),
        .pred_ready_o (pred_ready_o),
        .res_valid_i  (res_valid_i),
        .res_taken_i  (res_taken_i),
        .upd_en_o     (upd_en_o),
        .upd_idx_o    (upd_idx_o),
        .upd_result_o (upd_result_o),
        .init_o       (init_o),
        .mispredict_o (mispredict_o),
        .flush_o      (flush_o),
        .count_o      (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] idx;
    } pred_t;

    // Reference model state
    pred_t q[$];          // outstanding predictions, oldest first
    int    sweep_next;    // next index the init sweep issues; ENTRIES = sweep done
    int    flush_left;    // cycles of blocked flush window still ahead

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    function automatic logic model_ready();
        return (sweep_next >= ENTRIES) && (flush_left == 0) && (q.size() < DEPTH);
    endfunction

    task automatic apply_reset();
        rst_i        = 1'b1;
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        #2;
        q.delete();
        sweep_next = 0;
        flush_left = 0;
        chk("rst_upd_en",  32'(upd_en_o),     32'd0);
        chk("rst_upd_idx", 32'(upd_idx_o),    32'd0);
        chk("rst_result",  32'(upd_result_o), 32'd0);
        chk("rst_init",    32'(init_o),       32'd0);
        chk("rst_mispred", 32'(mispredict_o), 32'd0);
        chk("rst_flush",   32'(flush_o),      32'd0);
        chk("rst_count",   32'(count_o),      32'd0);
        chk("rst_ready",   32'(pred_ready_o), 32'd0);
        $display("step %0d: reset applied", step_no);
        rst_i = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic step(input logic pv, input logic pt, input logic [IDX_W-1:0] pidx,
                        input logic rv, input logic rt);
        logic             rdy;
        logic             do_push;
        logic             e_en, e_init, e_res, e_mis, e_flush;
        logic [IDX_W-1:0] e_idx;
        pred_t            h;
        step_no++;
        pred_valid_i = pv;
        pred_taken_i = pt;
        pred_idx_i   = pidx;
        res_valid_i  = rv;
        res_taken_i  = rt;
        rdy = model_ready();
        chk("ready_pre", 32'(pred_ready_o), 32'(rdy));

        e_en = 0; e_init = 0; e_res = 0; e_mis = 0; e_flush = 0; e_idx = '0;
        do_push = pv && rdy;
        if (sweep_next < ENTRIES) begin
            e_en  = 1; e_init = 1;
            e_idx = IDX_W'(sweep_next);
            sweep_next++;
            do_push = 0;
        end else if (flush_left > 0) begin
            flush_left--;
            e_flush = (flush_left > 0);
            do_push = 0;
        end else begin
            if (rv && q.size() > 0) begin
                h     = q.pop_front();
                e_en  = 1;
                e_idx = h.idx;
                e_res = rt;
                if (h.taken != rt) begin
                    e_mis = 1; e_flush = 1;
                    q.delete();
                    flush_left = FLUSH_CYC;
                    do_push = 0;
                end
            end
            if (do_push) q.push_back({pt, pidx});
        end

        @(posedge clk_i);
        #1;
        chk("upd_en",  32'(upd_en_o),     32'(e_en));
        chk("init",    32'(init_o),       32'(e_init));
        chk("mispred", 32'(mispredict_o), 32'(e_mis));
        chk("flush",   32'(flush_o),      32'(e_flush));
        chk("count",   32'(count_o),      32'(q.size()));
        chk("ready",   32'(pred_ready_o), 32'(model_ready()));
        if (e_en) begin
            chk("upd_idx", 32'(upd_idx_o), 32'(e_idx));
            if (!e_init) chk("upd_result", 32'(upd_result_o), 32'(e_res));
        end
        $display("step %0d: pv=%0d pt=%0d pidx=%0d rv=%0d rt=%0d -> en=%0d init=%0d idx=%0d res=%0d mis=%0d flush=%0d cnt=%0d",
                 step_no, pv, pt, pidx, rv, rt, upd_en_o, init_o, upd_idx_o,
                 upd_result_o, mispredict_o, flush_o, count_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    logic             r_pv, r_pt, r_rv, r_rt;
    logic [IDX_W-1:0] r_idx;

    initial begin
        rst_i = 1'b1; pred_valid_i = 0; pred_taken_i = 0; pred_idx_i = '0;
        res_valid_i = 0; res_taken_i = 0;
        sweep_next = 0; flush_left = 0;
        #1;
        apply_reset();

        // Init sweep: 16 strobes, then idle with ready high
        idle(ENTRIES + 1);

        // Correct predictions resolve in order
        step(1, 1, 4'd3, 0, 0);
        step(1, 0, 4'd5, 0, 0);
        step(1, 1, 4'd7, 0, 0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 1);
        idle(1);

        // Misprediction, flush window, ignored resolves during and after it
        step(1, 1, 4'd2, 0, 0);
        step(1, 1, 4'd9, 0, 0);
        step(1, 0, 4'd4, 1, 0);   // mismatch with a simultaneous push
        step(0, 0, '0, 1, 1);
        step(1, 1, 4'd1, 1, 0);
        step(0, 0, '0, 1, 1);     // empty-queue resolve in RUN
        idle(1);

        // Full queue blocks a push even with a simultaneous pop
        step(1, 1, 4'd10, 0, 0);
        step(1, 0, 4'd11, 0, 0);
        step(1, 1, 4'd12, 0, 0);
        step(1, 0, 4'd13, 0, 0);
        step(1, 1, 4'd14, 1, 1);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        idle(1);

        // Random traffic, mostly-correct resolutions
        for (int i = 0; i < 300; i++) begin
            r_pv  = ($urandom_range(0, 99) < 60);
            r_pt  = 1'($urandom_range(0, 1));
            r_idx = IDX_W'($urandom_range(0, ENTRIES - 1));
            r_rv  = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 9) < 8) r_rt = q[0].taken;
            else r_rt = 1'($urandom_range(0, 1));
            step(r_pv, r_pt, r_idx, r_rv, r_rt);
        end
        idle(3);

        // Reset during the flush window
        step(1, 1, 4'd6, 0, 0);
        step(0, 0, '0, 1, 0);
        apply_reset();
        // Reset again mid-sweep right after index 6 is issued
        idle(7);
        apply_reset();
        idle(ENTRIES + 1);
        step(1, 0, 4'd8, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencer for the 2-bit saturating-counter predictor bank, one counter per table index.
- After reset, sweeps every index to drive the bank's init writes.
- Tracks in-flight predictions in an in-order queue and matches each against its EX-stage resolution.
- Issues one update strobe per resolved branch.
- On a misprediction, empties the queue and holds a flush window for the pipeline.

Parameters:
IDX_W, 4, predictor table index width (2^IDX_W entries)
QLOG2, 2, log2 of in-flight queue depth (DEPTH = 2^QLOG2 = 4)
FLUSH_CYC, 2, flush_o assertion length in cycles (>=1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
pred_valid_i  in  1  ID stage issues a prediction
pred_taken_i  in  1  predicted direction
pred_idx_i  in  IDX_W  table index of the predicted branch
pred_ready_o  out  1  prediction accepted when high
res_valid_i  in  1  EX resolves the oldest in-flight branch
res_taken_i  in  1  actual direction
upd_en_o  out  1  write/update strobe to predictor bank
upd_idx_o  out  IDX_W  bank index for the strobe
upd_result_o  out  1  taken/not-taken for the counter update
init_o  out  1  with upd_en_o: bank loads reset state (strongly taken) at upd_idx_o
mispredict_o  out  1  one-cycle pulse on direction mismatch
flush_o  out  1  pipeline flush window
count_o  out  QLOG2+1  in-flight entries

Behaviour:
- All outputs are registered except pred_ready_o and count_o.
- Reset (async, any time, including mid-INIT/FLUSH):
  - state=INIT, init_cnt=0, queue empty (count 0, pointers 0), flush counter 0.
  - upd_en_o=0, upd_idx_o=0, upd_result_o=0, init_o=0, mispredict_o=0, flush_o=0.
- States:
  - INIT: each clock registers upd_en_o=1, init_o=1, upd_idx_o=init_cnt, then increments init_cnt.
    - After the edge that issues index 2^IDX_W-1, go to RUN. The sweep spans exactly 2^IDX_W consecutive strobe cycles, first strobe on the first edge after reset release.
    - pred_ready_o=0. res_valid_i is ignored.
  - RUN:
    - pred_ready_o = (count < DEPTH). A full queue blocks a push even if a pop occurs in the same cycle.
    - Push on pred_valid_i & pred_ready_o: store {pred_taken_i, pred_idx_i} at tail.
    - Resolve on res_valid_i & count>0: pop the head entry. Next cycle: upd_en_o=1, init_o=0, upd_idx_o=head idx, upd_result_o=res_taken_i (latency 1).
    - res_valid_i with count==0 is ignored: no strobe, no state change.
    - Simultaneous push and resolve with no mismatch: count unchanged, and FIFO order is kept.
    - Mismatch (head taken != res_taken_i):
      - The update strobe is still issued as above.
      - Same cycle as the strobe: mispredict_o=1 for one cycle, flush_o=1.
      - Entire queue cleared (count 0). A push in the resolving cycle is discarded.
      - Go to FLUSH.
  - FLUSH:
    - flush_o stays high for FLUSH_CYC total cycles, counting the first cycle, then RUN with flush_o=0.
    - pred_ready_o=0. res_valid_i and pred_valid_i are ignored.
- upd_en_o is low in every cycle without a strobe. init_o is high only during the INIT sweep.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset release, no inputs -> upd_en_o=init_o=1 for 16 consecutive cycles with upd_idx_o 0..15, then both low; pred_ready_o rises after the sweep.
- RUN: push (T,3),(N,5),(T,7), resolve T,N,T -> three strobes idx 3,5,7 with result 1,0,1, one cycle after each resolve; mispredict_o never high; count_o returns to 0.
- Push (T,2),(T,9), resolve N -> strobe idx 2 result 0, mispredict_o one pulse, flush_o high 2 cycles, count_o=0; a further res_valid_i does not strobe.
- Push 4 entries -> pred_ready_o=0 and count_o=4. A fifth pred_valid_i with a simultaneous correct resolve is not accepted; next cycle pred_ready_o=1.
- res_valid_i with empty queue in RUN -> no strobe, no mispredict.
- Assert rst_i during FLUSH and again mid-INIT at idx 6 -> all outputs 0 immediately; the sweep restarts at idx 0.
